// File: rtl/sub_operand_dispatcher.sv
// ---------------------------------------------------------------------------
// sub_operand_dispatcher
//
// Queues {minuend, subtrahend} pairs in a small FIFO and feeds them one at a
// time to an external multi-cycle subtractor. Each operation runs
// IDLE -> ISSUE -> WAIT -> IDLE. The result is held on a valid/ready output
// until it is consumed, and no new operation is issued while a result is
// still pending.
//
// Optional feature: define SUB_DISPATCH_TIMEOUT_EN to add a WAIT watchdog.
// If the subtractor does not complete within TIMEOUT WAIT cycles, the
// operation is dropped and timeout_err sets (sticky until reset). Without
// the macro, WAIT waits indefinitely and timeout_err is tied to 0.
//
// Parameters
//   WIDTH   operand / result width
//   DEPTH   operand FIFO entries (power of 2, >= 2)
//   TIMEOUT WAIT cycles before abort (only with SUB_DISPATCH_TIMEOUT_EN)
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-low
//   in_valid/in_ready/in_a/in_b   operand pair input handshake
//   sub_start      one-cycle start pulse to the subtractor
//   sub_a/sub_b    operands presented to the subtractor (held until next issue)
//   sub_result/sub_borrow/sub_underflow/sub_done  subtractor response
//   out_valid/out_ready/out_result/out_underflow  result output handshake
//   busy           FSM not idle or FIFO not empty
//   count          FIFO occupancy
//   timeout_err    sticky watchdog flag
// ---------------------------------------------------------------------------
module sub_operand_dispatcher #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 40
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,

    output logic                     sub_start,
    output logic [WIDTH-1:0]         sub_a,
    output logic [WIDTH-1:0]         sub_b,

    input  logic [WIDTH-1:0]         sub_result,
    input  logic                     sub_borrow,
    input  logic                     sub_underflow,
    input  logic                     sub_done,

    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_result,
    output logic                     out_underflow,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     timeout_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [1:0]           state_q,      state_d;
    logic [CW-1:0]        count_q,      count_d;
    logic [AW-1:0]        wr_ptr_q,     wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q,     rd_ptr_d;
    logic [WIDTH-1:0]     sub_a_q,      sub_a_d;
    logic [WIDTH-1:0]     sub_b_q,      sub_b_d;
    logic [WIDTH-1:0]     out_result_q, out_result_d;
    logic                 out_uf_q,     out_uf_d;
    logic                 out_valid_q,  out_valid_d;
    logic                 done_prev_q;

    logic [2*WIDTH-1:0]   mem_q [DEPTH];
    logic [2*WIDTH-1:0]   head;

    logic                 push;
    logic                 pop;
    logic                 done_rise;

    // The borrow output duplicates underflow for this dispatcher.
    logic                 unused_borrow;
    assign unused_borrow = sub_borrow;

`ifdef SUB_DISPATCH_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0]        wait_cnt_q,   wait_cnt_d;
    logic                 timeout_err_q, timeout_err_d;

    assign timeout_err = timeout_err_q;
`else
    localparam int unsigned unused_timeout = TIMEOUT;

    assign timeout_err = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // FIFO control
    // -----------------------------------------------------------------------
    // Readiness comes from the registered count only, so a full FIFO never
    // accepts a pair even in the cycle it is being popped.
    assign in_ready  = reset && (count_q < FULL_C);
    assign push      = in_valid && in_ready;
    assign pop       = (state_q == S_ISSUE);
    assign head      = mem_q[rd_ptr_q];

    // Completion is the rising edge of sub_done, so a level left high by the
    // previous operation cannot end the current WAIT.
    assign done_rise = sub_done && !done_prev_q;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_a, in_b};
        end
    end

    // -----------------------------------------------------------------------
    // Dispatch FSM
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        sub_a_d      = sub_a_q;
        sub_b_d      = sub_b_q;
        out_result_d = out_result_q;
        out_uf_d     = out_uf_q;
        out_valid_d  = out_valid_q;
`ifdef SUB_DISPATCH_TIMEOUT_EN
        wait_cnt_d    = wait_cnt_q;
        timeout_err_d = timeout_err_q;
`endif

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                // Operands are latched on the way into ISSUE so they are
                // already on sub_a/sub_b while sub_start is high.
                if ((count_q != '0) && !out_valid_q) begin
                    state_d            = S_ISSUE;
                    {sub_a_d, sub_b_d} = head;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
`ifdef SUB_DISPATCH_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            S_WAIT: begin
                if (done_rise) begin
                    state_d      = S_IDLE;
                    out_result_d = sub_result;
                    out_uf_d     = sub_underflow;
                    out_valid_d  = 1'b1;
                end
`ifdef SUB_DISPATCH_TIMEOUT_EN
                else if (wait_cnt_q == TO_LAST) begin
                    state_d       = S_IDLE;
                    timeout_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + TW'(1);
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            sub_a_q      <= '0;
            sub_b_q      <= '0;
            out_result_q <= '0;
            out_uf_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            done_prev_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            sub_a_q      <= sub_a_d;
            sub_b_q      <= sub_b_d;
            out_result_q <= out_result_d;
            out_uf_q     <= out_uf_d;
            out_valid_q  <= out_valid_d;
            done_prev_q  <= sub_done;
        end
    end

`ifdef SUB_DISPATCH_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign sub_start     = (state_q == S_ISSUE);
    assign sub_a         = sub_a_q;
    assign sub_b         = sub_b_q;
    assign out_valid     = out_valid_q;
    assign out_result    = out_result_q;
    assign out_underflow = out_uf_q;
    assign count         = count_q;
    assign busy          = (state_q != S_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_sub_operand_dispatcher.sv
module tb_sub_operand_dispatcher;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        sub_start;
    logic [15:0] sub_a;
    logic [15:0] sub_b;
    logic [15:0] sub_result;
    logic        sub_borrow;
    logic        sub_underflow;
    logic        sub_done;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic        out_underflow;
    logic        busy;
    logic [2:0]  count;
    logic        timeout_err;

    sub_operand_dispatcher #(
        .WIDTH   (16),
        .DEPTH   (4),
        .TIMEOUT (40)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_a          (in_a),
        .in_b          (in_b),
        .sub_start     (sub_start),
        .sub_a         (sub_a),
        .sub_b         (sub_b),
        .sub_result    (sub_result),
        .sub_borrow    (sub_borrow),
        .sub_underflow (sub_underflow),
        .sub_done      (sub_done),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_underflow (out_underflow),
        .busy          (busy),
        .count         (count),
        .timeout_err   (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed { logic [15:0] a; logic [15:0] b; } pair_t;
    typedef struct packed { logic [15:0] r; logic uf; }       res_t;

    pair_t       iss_q[$];
    res_t        sb_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] cur_a;
    logic [15:0] cur_b;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Offer one pair for one cycle; it must be accepted.
    task automatic push(input logic [15:0] a, input logic [15:0] b);
        pair_t p;
        res_t  r;
        in_a = a; in_b = b; in_valid = 1'b1;
        #1;
        chk("push_ready", 32'(in_ready), 1);
        if (in_ready) begin
            p.a = a; p.b = b;
            r.r = a - b; r.uf = (a < b);
            iss_q.push_back(p);
            sb_q.push_back(r);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic check_issue();
        pair_t p;
        chk("issue_start", 32'(sub_start), 1);
        if (iss_q.size() > 0) begin
            p = iss_q.pop_front();
            chk("issue_a", 32'(sub_a), 32'(p.a));
            chk("issue_b", 32'(sub_b), 32'(p.b));
            cur_a = p.a;
            cur_b = p.b;
        end else begin
            chk("issue_unexpected", 32'(sub_start), 0);
        end
    endtask

    task automatic wait_start();
        int n = 0;
        while (!sub_start && n < 30) begin
            tick();
            n++;
        end
        check_issue();
    endtask

    // Subtractor model: dly cycles with sub_done left at its old level,
    // then a clean low-to-high edge carrying the difference.
    task automatic finish_op(input int dly);
        repeat (dly) begin
            tick();
            chk("wait_no_valid", 32'(out_valid), 0);
        end
        sub_done = 1'b0;
        tick();
        sub_result    = cur_a - cur_b;
        sub_underflow = (cur_a < cur_b);
        sub_borrow    = (cur_a < cur_b);
        sub_done      = 1'b1;
        tick();
        chk("done_valid", 32'(out_valid), 1);
        sub_result    = 16'hDEAD;
        sub_underflow = 1'b0;
    endtask

    task automatic take();
        res_t r;
        int   n = 0;
        out_ready = 1'b1;
        while (!out_valid && n < 30) begin
            tick();
            n++;
        end
        chk("take_valid", 32'(out_valid), 1);
        if (sb_q.size() > 0) begin
            r = sb_q.pop_front();
            chk("take_result", 32'(out_result), 32'(r.r));
            chk("take_underflow", 32'(out_underflow), 32'(r.uf));
        end
        tick();
        out_ready = 1'b0;
        chk("take_clear", 32'(out_valid), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        pair_t p;
        res_t  r;

        reset = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        sub_result = '0; sub_borrow = 1'b0; sub_underflow = 1'b0; sub_done = 1'b0;
        out_ready = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_count",       32'(count), 0);
        chk("rst_in_ready",    32'(in_ready), 0);
        chk("rst_sub_start",   32'(sub_start), 0);
        chk("rst_sub_a",       32'(sub_a), 0);
        chk("rst_sub_b",       32'(sub_b), 0);
        chk("rst_out_valid",   32'(out_valid), 0);
        chk("rst_out_result",  32'(out_result), 0);
        chk("rst_out_uf",      32'(out_underflow), 0);
        chk("rst_busy",        32'(busy), 0);
        chk("rst_timeout_err", 32'(timeout_err), 0);
        reset = 1'b1;
        #1;
        chk("rst_release_ready", 32'(in_ready), 1);

        // Latency: push in cycle k, sub_start in k+2, operands held in WAIT
        push(16'd200, 16'd100);
        chk("lat_k1_start", 32'(sub_start), 0);
        chk("lat_k1_count", 32'(count), 1);
        chk("lat_k1_busy",  32'(busy), 1);
        tick();
        check_issue();
        tick();
        chk("wait_start_low", 32'(sub_start), 0);
        chk("wait_hold_a",    32'(sub_a), 200);
        chk("wait_hold_b",    32'(sub_b), 100);
        chk("wait_count",     32'(count), 0);
        chk("wait_busy",      32'(busy), 1);
        finish_op(2);
        repeat (3) begin
            tick();
            chk("hold_valid",  32'(out_valid), 1);
            chk("hold_result", 32'(out_result), 100);
            chk("hold_uf",     32'(out_underflow), 0);
        end
        take();

        // Underflow cases; sub_done stays high between ops (level must not complete)
        push(16'd100, 16'd200);
        wait_start();
        finish_op(2);
        take();
        push(16'd0, 16'd1);
        wait_start();
        finish_op(0);
        take();

        // Full FIFO: pending result blocks issue, 5 back-to-back offers
        push(16'd7, 16'd3);
        wait_start();
        finish_op(1);
        for (int i = 0; i < 5; i++) begin
            in_a = 16'(1000 + i * 11); in_b = 16'(i * 3); in_valid = 1'b1;
            #1;
            chk("fill_ready", 32'(in_ready), (i < 4) ? 1 : 0);
            if (in_ready) begin
                p.a = in_a; p.b = in_b;
                r.r = in_a - in_b; r.uf = (in_a < in_b);
                iss_q.push_back(p);
                sb_q.push_back(r);
            end
            tick();
        end
        chk("full_count", 32'(count), 4);
        chk("full_ready", 32'(in_ready), 0);
        repeat (3) begin
            tick();
            chk("blocked_no_start", 32'(sub_start), 0);
            chk("blocked_valid",    32'(out_valid), 1);
            chk("blocked_ready",    32'(in_ready), 0);
        end
        take();
        tick();
        check_issue();
        chk("full_pop_no_push", 32'(in_ready), 0);
        tick();
        chk("after_pop_ready", 32'(in_ready), 1);
        chk("after_pop_count", 32'(count), 3);
        p.a = in_a; p.b = in_b;
        r.r = in_a - in_b; r.uf = (in_a < in_b);
        iss_q.push_back(p);
        sb_q.push_back(r);
        tick();
        in_valid = 1'b0;
        chk("refill_count", 32'(count), 4);
        finish_op(1);
        take();
        repeat (4) begin
            wait_start();
            finish_op(1);
            take();
        end
        chk("drained_busy", 32'(busy), 0);

        // Reset mid-WAIT with 3 pairs queued
        sub_done = 1'b0;
        push(16'd50, 16'd8);
        wait_start();
        push(16'd11, 16'd2);
        push(16'd12, 16'd3);
        push(16'd13, 16'd4);
        chk("pre_rst_count", 32'(count), 3);
        reset = 1'b0;
        tick();
        chk("mid_rst_count",     32'(count), 0);
        chk("mid_rst_out_valid", 32'(out_valid), 0);
        chk("mid_rst_busy",      32'(busy), 0);
        chk("mid_rst_start",     32'(sub_start), 0);
        reset = 1'b1;
        #1;
        chk("mid_rst_release_ready", 32'(in_ready), 1);
        iss_q.delete();
        sb_q.delete();
        sub_done = 1'b1;
        repeat (3) begin
            tick();
            chk("orphan_done_valid", 32'(out_valid), 0);
            chk("orphan_done_busy",  32'(busy), 0);
            chk("orphan_done_start", 32'(sub_start), 0);
        end

        // Recovery after reset
        push(16'd5, 16'd9);
        wait_start();
        finish_op(1);
        take();

`ifdef SUB_DISPATCH_TIMEOUT_EN
        // Watchdog: first op never completes, second op issues after abort
        sub_done = 1'b0;
        push(16'd1, 16'd1);
        push(16'd2, 16'd1);
        check_issue();
        repeat (40) tick();
        chk("to_before",       32'(timeout_err), 0);
        chk("to_before_valid", 32'(out_valid), 0);
        tick();
        chk("to_set",       32'(timeout_err), 1);
        chk("to_set_valid", 32'(out_valid), 0);
        chk("to_set_start", 32'(sub_start), 0);
        if (sb_q.size() > 0) begin
            r = sb_q.pop_front();
        end
        tick();
        check_issue();
        finish_op(0);
        take();
        chk("to_sticky", 32'(timeout_err), 1);
`else
        // No watchdog: WAIT persists indefinitely
        sub_done = 1'b0;
        push(16'd30, 16'd10);
        wait_start();
        repeat (60) tick();
        chk("nto_valid", 32'(out_valid), 0);
        chk("nto_busy",  32'(busy), 1);
        chk("nto_err",   32'(timeout_err), 0);
        finish_op(0);
        take();
        chk("nto_err_end", 32'(timeout_err), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sub_operand_dispatcher.md
SUB_OPERAND_DISPATCHER -- requirements
Module: sub_operand_dispatcher

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width.
REQ-002 SHALL have parameter DEPTH, default 4, operand-FIFO entries (power of 2, >=2).
REQ-003 SHALL have parameter TIMEOUT, default 40, max WAIT cycles before abort (used only with the Configuration macro).
REQ-004 SHALL have ports: clk in 1, rising-edge clock; reset in 1, synchronous, active-low.
REQ-005 SHALL have ports: in_valid in 1, operand pair offered; in_ready out 1, pair accepted when both high; in_a in WIDTH, minuend; in_b in WIDTH, subtrahend.
REQ-006 SHALL have ports: sub_start out 1, one-cycle start pulse to subtractor; sub_a out WIDTH; sub_b out WIDTH.
REQ-007 SHALL have ports: sub_result in WIDTH; sub_borrow in 1; sub_underflow in 1; sub_done in 1, subtractor completion level.
REQ-008 SHALL have ports: out_valid out 1; out_ready in 1; out_result out WIDTH; out_underflow out 1; busy out 1, state != IDLE or FIFO non-empty; count out clog2(DEPTH)+1, FIFO occupancy; timeout_err out 1, sticky watchdog flag.

Function
REQ-009 SHALL hold a DEPTH-entry FIFO of {in_a,in_b}; push when in_valid && in_ready; in_ready = (count < DEPTH) && reset deasserted, from registered count only (no push into a full FIFO even when a pop happens in the same cycle).
REQ-010 SHALL run FSM IDLE -> ISSUE -> WAIT -> IDLE.
REQ-011 IDLE SHALL go to ISSUE when FIFO non-empty and out_valid == 0; otherwise stay in IDLE.
REQ-012 ISSUE SHALL last exactly one cycle: sub_start = 1, sub_a/sub_b = FIFO head, head popped; then go to WAIT.
REQ-013 sub_a/sub_b SHALL hold the issued values until the next ISSUE; sub_start SHALL be 0 in all states except ISSUE.
REQ-014 WAIT SHALL detect completion on the rising edge of sub_done (sub_done high, previous-cycle sample low); a level held over from the prior operation SHALL NOT complete WAIT.
REQ-015 On completion detected in cycle m, out_result <= sub_result and out_underflow <= sub_underflow, with out_valid = 1 from cycle m+1; FSM SHALL return to IDLE.
REQ-016 out_valid SHALL stay high, and out_result/out_underflow stable, until out_valid && out_ready, then clear on the next edge.
REQ-017 Latency: push handshake in cycle k into an empty FIFO while IDLE with out_valid 0 SHALL give sub_start high in cycle k+2.
REQ-018 Simultaneous push and ISSUE-pop SHALL update count by net 0; push into an empty FIFO SHALL not be issued in the same cycle.
REQ-019 FIFO pointers SHALL wrap modulo DEPTH; operands SHALL issue in arrival order.

Reset
REQ-020 While reset == 0 at a clock edge: state IDLE, FIFO empty, count 0, in_ready 0, sub_start 0, sub_a/sub_b 0, out_valid 0, out_result 0, out_underflow 0, busy 0, timeout_err 0, done edge detector cleared.
REQ-021 Reset during ISSUE or WAIT SHALL abandon the operation and discard all queued pairs; in_ready SHALL be 1 in the first cycle after reset returns high.

Configuration
REQ-022 With SUB_DISPATCH_TIMEOUT_EN defined, WAIT SHALL count cycles; if TIMEOUT cycles elapse without completion, FSM SHALL go to IDLE, discard the operation (out_valid unchanged), and set timeout_err = 1 until reset.
REQ-023 Without SUB_DISPATCH_TIMEOUT_EN, WAIT SHALL wait indefinitely, and timeout_err SHALL remain present and tied to 0.

Verification
REQ-024 Push (200,100) at cycle k -> sub_start pulse in k+2 with sub_a=200, sub_b=100; after sub_done rises, out_result=100, out_underflow=0.
REQ-025 Push (100,200) -> out_result=65436, out_underflow=1; push (0,1) -> 65535, underflow 1.
REQ-026 Subtractor never started, 5 back-to-back pushes with DEPTH=4 -> 4 accepted, count=4, in_ready=0; 5th held until a pop.
REQ-027 out_ready held 0 with 2 pairs queued -> first result held, second not issued (no sub_start) until out_ready=1 for one cycle.
REQ-028 Reset asserted mid-WAIT with 3 pairs queued -> next cycle count=0, out_valid=0, busy=0; a later sub_done edge produces no output.
REQ-029 With SUB_DISPATCH_TIMEOUT_EN, sub_done held low -> after 40 WAIT cycles timeout_err=1, FSM IDLE, next queued pair issued.
